// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master indices for the two-master arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic logic [1:0] master_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ahb_cpl_buffer.sv
// Per-master completion buffer: holds one finished data phase (rdata/resp)
// for a master that was stalled on its next address, until it is regranted.
module ahb_cpl_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    input  logic                  resp_in,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  resp
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;

    always_comb begin
        valid_d = valid_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        if (fill) begin
            valid_d = 1'b1;
            rdata_d = rdata_in;
            resp_d  = resp_in;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
        end
    end

    assign valid = valid_q;
    assign rdata = rdata_q;
    assign resp  = resp_q;

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter with burst-hold limit. Define ARB_ROUND_ROBIN_EN
// for round-robin contention; otherwise M0 has fixed priority.
module ahb_lite_arbiter2
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] M0HADDR,
    input  logic [1:0]            M0HTRANS,
    input  logic [2:0]            M0HSIZE,
    input  logic                  M0HWRITE,
    input  logic [DATA_WIDTH-1:0] M0HWDATA,
    output logic                  M0HREADY,
    output logic [DATA_WIDTH-1:0] M0HRDATA,
    output logic                  M0HRESP,
    input  logic [ADDR_WIDTH-1:0] M1HADDR,
    input  logic [1:0]            M1HTRANS,
    input  logic [2:0]            M1HSIZE,
    input  logic                  M1HWRITE,
    input  logic [DATA_WIDTH-1:0] M1HWDATA,
    output logic                  M1HREADY,
    output logic [DATA_WIDTH-1:0] M1HRDATA,
    output logic                  M1HRESP,
    output logic [ADDR_WIDTH-1:0] SHADDR,
    output logic [1:0]            SHTRANS,
    output logic [2:0]            SHSIZE,
    output logic                  SHWRITE,
    output logic [DATA_WIDTH-1:0] SHWDATA,
    input  logic                  SHREADY,
    input  logic [DATA_WIDTH-1:0] SHRDATA,
    input  logic                  SHRESP,
    output logic [1:0]            GRANT
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic       addr_owner_q, addr_owner_d;
    logic       data_active_q, data_active_d;
    logic       data_owner_q, data_owner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic       rr_last_q, rr_last_d;
`endif

    logic [1:0]                 req, fill, drain, buf_vld, buf_resp, hready, hresp;
    logic [1:0][DATA_WIDTH-1:0] buf_rdata, hrdata;
    logic [1:0]                 own_trans, gnt_trans;
    logic                       lock, contend_win, gnt, gnt_req;

    // Arbitration: an unexpired SEQ burst keeps the bus; an expired one hands
    // it to the waiting master; otherwise the contention policy decides.
    always_comb begin
        req         = {M1HTRANS[1], M0HTRANS[1]};
        own_trans   = addr_owner_q ? M1HTRANS : M0HTRANS;
        lock        = (own_trans == HTRANS_SEQ) && (hold_cnt_q < HOLD_MAX);
`ifdef ARB_ROUND_ROBIN_EN
        contend_win = ~rr_last_q;
`else
        contend_win = M0;
`endif
        if (hold_cnt_q >= HOLD_MAX) contend_win = ~addr_owner_q;
        gnt = addr_owner_q;
        if (SHREADY && !lock) begin
            if (req[0] && req[1]) gnt = contend_win;
            else if (req[0])      gnt = M0;
            else if (req[1])      gnt = M1;
        end
        gnt_req   = req[gnt];
        gnt_trans = gnt ? M1HTRANS : M0HTRANS;
    end

    always_comb begin
        addr_owner_d  = addr_owner_q;
        data_active_d = data_active_q;
        data_owner_d  = data_owner_q;
        hold_cnt_d    = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d     = rr_last_q;
`endif
        if (SHREADY) begin
            addr_owner_d  = gnt;
            data_active_d = gnt_req;
            data_owner_d  = gnt;
            // An idle cycle breaks the run of consecutive transfers.
            if (!gnt_req)                   hold_cnt_d = 8'd0;
            else if (gnt != addr_owner_q)   hold_cnt_d = 8'd1;
            else if (hold_cnt_q < HOLD_MAX) hold_cnt_d = hold_cnt_q + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
            if (gnt != addr_owner_q) rr_last_d = gnt;
`endif
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_owner_q  <= M0;
            data_active_q <= 1'b0;
            data_owner_q  <= M0;
            hold_cnt_q    <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q     <= M1;
`endif
        end else begin
            addr_owner_q  <= addr_owner_d;
            data_active_q <= data_active_d;
            data_owner_q  <= data_owner_d;
            hold_cnt_q    <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q     <= rr_last_d;
`endif
        end
    end

    // A master whose data completes while its next address is refused is held
    // off (HREADY low) and gets the data from its buffer when regranted.
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            logic own;
            own       = data_active_q && (data_owner_q == 1'(x));
            fill[x]   = SHREADY && own && req[x] && (gnt != 1'(x));
            drain[x]  = SHREADY && buf_vld[x] && (gnt == 1'(x));
            hready[x] = 1'b1;
            hrdata[x] = '0;
            hresp[x]  = HRESP_OKAY;
            if (buf_vld[x]) begin
                hready[x] = SHREADY && (gnt == 1'(x));
                hrdata[x] = buf_rdata[x];
                hresp[x]  = buf_resp[x];
            end else begin
                if (own) begin
                    hrdata[x] = SHRDATA;
                    hresp[x]  = SHRESP;
                end
                if (req[x] && (gnt != 1'(x))) hready[x] = 1'b0;
                else if (req[x] || own)       hready[x] = SHREADY;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        ahb_cpl_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
            .clk      (HCLK),
            .rst      (HRESET),
            .fill     (fill[g]),
            .drain    (drain[g]),
            .rdata_in (SHRDATA),
            .resp_in  (SHRESP),
            .valid    (buf_vld[g]),
            .rdata    (buf_rdata[g]),
            .resp     (buf_resp[g])
        );
    end

    assign SHADDR   = gnt ? M1HADDR : M0HADDR;
    assign SHTRANS  = gnt_req ? gnt_trans : HTRANS_IDLE;
    assign SHSIZE   = gnt ? M1HSIZE : M0HSIZE;
    assign SHWRITE  = gnt ? M1HWRITE : M0HWRITE;
    assign SHWDATA  = data_owner_q ? M1HWDATA : M0HWDATA;
    assign GRANT    = master_onehot(gnt);
    assign M0HREADY = hready[0];
    assign M0HRDATA = hrdata[0];
    assign M0HRESP  = hresp[0];
    assign M1HREADY = hready[1];
    assign M1HRDATA = hrdata[1];
    assign M1HRESP  = hresp[1];

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Directed bench for ahb_lite_arbiter2 (default build: fixed priority, MAX_HOLD=8).
module tb_ahb_lite_arbiter2;

    logic        HCLK, HRESET;
    logic [31:0] M0HADDR, M1HADDR, M0HWDATA, M1HWDATA, M0HRDATA, M1HRDATA;
    logic [1:0]  M0HTRANS, M1HTRANS, SHTRANS, GRANT;
    logic [2:0]  M0HSIZE, M1HSIZE, SHSIZE;
    logic        M0HWRITE, M1HWRITE, M0HREADY, M1HREADY, M0HRESP, M1HRESP;
    logic [31:0] SHADDR, SHWDATA, SHRDATA;
    logic        SHWRITE, SHREADY, SHRESP;

    int tests = 0;
    int fails = 0;

    ahb_lite_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0HADDR(M0HADDR), .M0HTRANS(M0HTRANS), .M0HSIZE(M0HSIZE), .M0HWRITE(M0HWRITE),
        .M0HWDATA(M0HWDATA), .M0HREADY(M0HREADY), .M0HRDATA(M0HRDATA), .M0HRESP(M0HRESP),
        .M1HADDR(M1HADDR), .M1HTRANS(M1HTRANS), .M1HSIZE(M1HSIZE), .M1HWRITE(M1HWRITE),
        .M1HWDATA(M1HWDATA), .M1HREADY(M1HREADY), .M1HRDATA(M1HRDATA), .M1HRESP(M1HRESP),
        .SHADDR(SHADDR), .SHTRANS(SHTRANS), .SHSIZE(SHSIZE), .SHWRITE(SHWRITE),
        .SHWDATA(SHWDATA), .SHREADY(SHREADY), .SHRDATA(SHRDATA), .SHRESP(SHRESP),
        .GRANT(GRANT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        M0HADDR = '0; M0HTRANS = 2'b00; M0HSIZE = 3'b010; M0HWRITE = 1'b0; M0HWDATA = '0;
        M1HADDR = '0; M1HTRANS = 2'b00; M1HSIZE = 3'b010; M1HWRITE = 1'b0; M1HWDATA = '0;
        SHREADY = 1'b1; SHRDATA = '0; SHRESP = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESET = 1'b1;
        #2;
        tests++; if (GRANT !== 2'b01) begin fails++; $display("FAIL reset_grant got %b exp 01", GRANT); end
        tests++; if (SHTRANS !== 2'b00) begin fails++; $display("FAIL reset_shtrans got %b exp 00", SHTRANS); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b11) begin fails++; $display("FAIL reset_hready got %b exp 11", {M0HREADY, M1HREADY}); end
        tests++; if ({M0HRDATA, M1HRDATA} !== 64'h0) begin fails++; $display("FAIL reset_hrdata got %h exp 0", {M0HRDATA, M1HRDATA}); end
        tests++; if ({M0HRESP, M1HRESP} !== 2'b00) begin fails++; $display("FAIL reset_hresp got %b exp 00", {M0HRESP, M1HRESP}); end
        step();
        HRESET = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        M0HTRANS = 2'b10; M0HADDR = 32'h0000_0010; M0HWRITE = 1'b1;
        #2;
        tests++; if (SHTRANS !== 2'b10) begin fails++; $display("FAIL wr_shtrans got %b exp 10", SHTRANS); end
        tests++; if (SHADDR !== 32'h10) begin fails++; $display("FAIL wr_shaddr got %h exp 00000010", SHADDR); end
        tests++; if (SHWRITE !== 1'b1) begin fails++; $display("FAIL wr_shwrite got %b exp 1", SHWRITE); end
        tests++; if (M1HREADY !== 1'b1) begin fails++; $display("FAIL wr_m1ready0 got %b exp 1", M1HREADY); end
        step();
        M0HTRANS = 2'b00; M0HWRITE = 1'b0; M0HWDATA = 32'hA5A5_A5A5;
        #2;
        tests++; if (SHWDATA !== 32'hA5A5_A5A5) begin fails++; $display("FAIL wr_shwdata got %h exp a5a5a5a5", SHWDATA); end
        tests++; if (SHTRANS !== 2'b00) begin fails++; $display("FAIL wr_shtrans_idle got %b exp 00", SHTRANS); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b11) begin fails++; $display("FAIL wr_hready1 got %b exp 11", {M0HREADY, M1HREADY}); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_contention();
        M0HTRANS = 2'b10; M0HADDR = 32'h100;
        M1HTRANS = 2'b10; M1HADDR = 32'h200;
        #2;
        tests++; if (GRANT !== 2'b01) begin fails++; $display("FAIL cont_grant0 got %b exp 01", GRANT); end
        tests++; if (SHADDR !== 32'h100) begin fails++; $display("FAIL cont_addr0 got %h exp 00000100", SHADDR); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b10) begin fails++; $display("FAIL cont_ready0 got %b exp 10", {M0HREADY, M1HREADY}); end
        step();
        M0HTRANS = 2'b00; SHRDATA = 32'h11;
        #2;
        tests++; if (GRANT !== 2'b10) begin fails++; $display("FAIL cont_grant1 got %b exp 10", GRANT); end
        tests++; if (SHADDR !== 32'h200) begin fails++; $display("FAIL cont_addr1 got %h exp 00000200", SHADDR); end
        tests++; if (M0HRDATA !== 32'h11) begin fails++; $display("FAIL cont_m0data got %h exp 00000011", M0HRDATA); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b11) begin fails++; $display("FAIL cont_ready1 got %b exp 11", {M0HREADY, M1HREADY}); end
        step();
        M1HTRANS = 2'b00; SHRDATA = 32'h22;
        #2;
        tests++; if (M1HRDATA !== 32'h22) begin fails++; $display("FAIL cont_m1data got %h exp 00000022", M1HRDATA); end
        tests++; if (M0HRDATA !== 32'h0) begin fails++; $display("FAIL cont_m0quiet got %h exp 0", M0HRDATA); end
        tests++; if (M1HREADY !== 1'b1) begin fails++; $display("FAIL cont_m1ready got %b exp 1", M1HREADY); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_burst_hold();
        M1HTRANS = 2'b10; M1HADDR = 32'h2000;
        for (int k = 0; k < 8; k++) begin
            M0HTRANS = (k == 0) ? 2'b10 : 2'b11;
            M0HADDR  = 32'h1000 + 32'(4 * k);
            SHRDATA  = 32'hD0 + 32'(k);
            #2;
            tests++; if (GRANT !== 2'b01) begin fails++; $display("FAIL burst_grant k=%0d got %b exp 01", k, GRANT); end
            tests++; if (M1HREADY !== 1'b0) begin fails++; $display("FAIL burst_m1wait k=%0d got %b exp 0", k, M1HREADY); end
            if (k > 0) begin
                tests++; if (M0HRDATA !== 32'hD0 + 32'(k)) begin fails++; $display("FAIL burst_data k=%0d got %h exp %h", k, M0HRDATA, 32'hD0 + 32'(k)); end
            end
            step();
        end
        M0HTRANS = 2'b11; M0HADDR = 32'h1020; SHRDATA = 32'hD8;
        #2;
        tests++; if (GRANT !== 2'b10) begin fails++; $display("FAIL burst_switch_grant got %b exp 10", GRANT); end
        tests++; if (SHADDR !== 32'h2000) begin fails++; $display("FAIL burst_switch_addr got %h exp 00002000", SHADDR); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b01) begin fails++; $display("FAIL burst_switch_ready got %b exp 01", {M0HREADY, M1HREADY}); end
        step();
        M1HTRANS = 2'b00; SHRDATA = 32'h77;
        #2;
        tests++; if (GRANT !== 2'b01) begin fails++; $display("FAIL burst_regrant got %b exp 01", GRANT); end
        tests++; if (M0HRDATA !== 32'hD8) begin fails++; $display("FAIL burst_bufdata got %h exp 000000d8", M0HRDATA); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b11) begin fails++; $display("FAIL burst_drain_ready got %b exp 11", {M0HREADY, M1HREADY}); end
        tests++; if (M1HRDATA !== 32'h77) begin fails++; $display("FAIL burst_m1data got %h exp 00000077", M1HRDATA); end
        step();
        for (int c = 10; c <= 13; c++) begin
            M0HTRANS = (c == 13) ? 2'b00 : 2'b11;
            M0HADDR  = 32'h1000 + 32'(4 * (c - 1));
            SHRDATA  = 32'hD0 + 32'(c - 1);
            #2;
            tests++; if (M0HRDATA !== 32'hD0 + 32'(c - 1)) begin fails++; $display("FAIL burst_tail c=%0d got %h exp %h", c, M0HRDATA, 32'hD0 + 32'(c - 1)); end
            tests++; if (M0HREADY !== 1'b1) begin fails++; $display("FAIL burst_tail_ready c=%0d got %b exp 1", c, M0HREADY); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_slave_wait();
        M1HTRANS = 2'b10; M1HADDR = 32'h300;
        step();
        M1HTRANS = 2'b00; M0HTRANS = 2'b10; M0HADDR = 32'h400; SHREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #2;
            tests++; if (GRANT !== 2'b10) begin fails++; $display("FAIL wait_grant w=%0d got %b exp 10", w, GRANT); end
            tests++; if ({M0HREADY, M1HREADY} !== 2'b00) begin fails++; $display("FAIL wait_ready w=%0d got %b exp 00", w, {M0HREADY, M1HREADY}); end
            step();
        end
        SHREADY = 1'b1; SHRDATA = 32'h33;
        #2;
        tests++; if (GRANT !== 2'b01) begin fails++; $display("FAIL wait_release_grant got %b exp 01", GRANT); end
        tests++; if (M1HRDATA !== 32'h33) begin fails++; $display("FAIL wait_m1data got %h exp 00000033", M1HRDATA); end
        tests++; if ({M0HREADY, M1HREADY} !== 2'b11) begin fails++; $display("FAIL wait_release_ready got %b exp 11", {M0HREADY, M1HREADY}); end
        step();
        M0HTRANS = 2'b00; SHRDATA = 32'h44;
        #2;
        tests++; if (M0HRDATA !== 32'h44) begin fails++; $display("FAIL wait_m0data got %h exp 00000044", M0HRDATA); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_error();
        M0HTRANS = 2'b10; M0HADDR = 32'h500;
        step();
        M0HTRANS = 2'b00; SHREADY = 1'b0; SHRESP = 1'b1;
        #2;
        tests++; if ({M0HRESP, M0HREADY} !== 2'b10) begin fails++; $display("FAIL err_first got resp,ready=%b exp 10", {M0HRESP, M0HREADY}); end
        step();
        SHREADY = 1'b1;
        #2;
        tests++; if ({M0HRESP, M0HREADY} !== 2'b11) begin fails++; $display("FAIL err_second got resp,ready=%b exp 11", {M0HRESP, M0HREADY}); end
        step();
        SHRESP = 1'b0;
        #2;
        tests++; if ({M0HRESP, M0HREADY} !== 2'b01) begin fails++; $display("FAIL err_nobuf got resp,ready=%b exp 01", {M0HRESP, M0HREADY}); end
        step();
    endtask

    task automatic test_reset_mid();
        M1HTRANS = 2'b10; M1HADDR = 32'h600;
        step();
        M1HADDR = 32'h604; M0HTRANS = 2'b10; M0HADDR = 32'h700; SHRDATA = 32'h66;
        #2;
        tests++; if ({GRANT, M1HREADY} !== 3'b010) begin fails++; $display("FAIL rst_fill got grant,m1ready=%b exp 010", {GRANT, M1HREADY}); end
        step();
        M0HADDR = 32'h704; SHRDATA = 32'h0;
        #2;
        tests++; if (M1HRDATA !== 32'h66) begin fails++; $display("FAIL rst_buffull got %h exp 00000066", M1HRDATA); end
        HRESET = 1'b1;
        idle_inputs();
        #1;
        tests++; if ({GRANT, M0HREADY, M1HREADY} !== 4'b0111) begin fails++; $display("FAIL rst_async got grant,ready=%b exp 0111", {GRANT, M0HREADY, M1HREADY}); end
        tests++; if (M1HRDATA !== 32'h0) begin fails++; $display("FAIL rst_discard got %h exp 0", M1HRDATA); end
        step();
        HRESET = 1'b0;
        M0HTRANS = 2'b10; M1HTRANS = 2'b10;
        #2;
        tests++; if (GRANT !== 2'b01) begin fails++; $display("FAIL rst_fixedprio got %b exp 01", GRANT); end
        tests++; if ({M1HREADY, M1HRDATA} !== 33'h0) begin fails++; $display("FAIL rst_bufempty got ready=%b data=%h exp 0/0", M1HREADY, M1HRDATA); end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_burst_hold();
        test_slave_wait();
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
